rst_seq_100: RTL and testbench
==============================

# rst_seq_100

Reset sequencer for the J68 system in the 100 MHz domain. It turns the raw board/testbench reset into a power-on stretch and releases up to eight per-stage resets one after another: clocking, SDRAM controller, peripherals, then CPU. Each stage release waits for the previous stage's ready indication, guarded by a timeout. A handshaked soft-reset request, driven by the CPU RESET instruction or the debug port, re-runs the release sequence without repeating the power-on stretch.

## Interface
Parameters:
- N_STAGES, 3: number of sequenced reset outputs, legal 1..8.
- STRETCH_W, 13: power-on stretch length is 2^STRETCH_W cycles (8192 by default).
- GAP_CYC, 16: idle cycles before each stage release, legal 1..255.
- TMO_W, 16: ready-wait timeout is 2^TMO_W-1 cycles.

Ports:
- clk_100  in  1  100 MHz system clock.
- rst_100  in  1  Reset. Asynchronous and active-high.
- soft_req  in  1  Soft-reset request. Level signal, held high until soft_ack is seen.
- soft_ack  out  1  One-cycle acknowledge of soft_req.
- stage_rdy  in  N_STAGES  Per-stage ready. Tie a bit high if that stage has no ready signal.
- rst_out  out  N_STAGES  Per-stage reset, active-high, registered.
- seq_done  out  1  High while all stages are released and the sequencer is in RUN.
- tmo_err  out  1  Sticky flag: a stage timed out.
- tmo_stage  out  3  Index of the last stage that timed out.

## Operation
- Reset values: rst_out all ones, soft_ack 0, seq_done 0, tmo_err 0, tmo_stage 0, state STRETCH, idx 0, counters 0.
- rst_100 assertion forces all outputs to their reset values asynchronously, in any state.
- rst_100 deassertion passes through a 2-flop synchronizer. The FSM is held in STRETCH while the synchronized reset is high.
- STRETCH: count 2^STRETCH_W cycles, then go to GAP with idx=0.
- GAP: count GAP_CYC cycles. On the final count, clear rst_out[idx] and go to WAIT.
- WAIT: the timeout counter runs.
  - stage_rdy[idx]=1: if idx=N_STAGES-1, go to RUN and set seq_done=1. Otherwise increment idx and go to GAP.
  - Counter reaches 2^TMO_W-1 with rdy still 0: set tmo_err=1 and tmo_stage=idx, then continue exactly as if rdy had been seen.
  - rdy and the timeout in the same cycle: rdy wins, no error is recorded.
- RUN: soft_req=1 causes, on the next edge:
  - soft_ack=1 for one cycle.
  - rst_out all ones, seq_done=0.
  - State goes to SOFT.
- SOFT: hold all resets for GAP_CYC cycles, then go to GAP with idx=0. The stretch is skipped.
- soft_req is ignored in every state except RUN.
- A requester still holding soft_req when the sequencer re-enters RUN triggers another soft reset.
- tmo_err and tmo_stage are cleared only by rst_100. A soft reset does not clear them.
- Stages release strictly in index order. rst_out bits never deassert out of order, and a released bit stays low until a soft reset or rst_100.

## Timing
- Edges are counted from the first clk_100 edge after rst_100 falls, which is edge 1.
- The synchronized reset drops at edge 2. STRETCH ends at edge 2+2^STRETCH_W.
- rst_out[0] falls at edge 2+2^STRETCH_W+GAP_CYC, which is edge 8210 with defaults.
- With stage_rdy tied high, stage k+1 falls GAP_CYC+1 cycles after stage k.
- seq_done rises 1 cycle after the last stage's rdy is sampled.
- From soft_req sampled high in RUN:
  - soft_ack and rst_out all ones at the next edge, edge S.
  - rst_out[0] falls at edge S+2·GAP_CYC.
- Timeout: tmo_err rises 2^TMO_W-1 cycles after WAIT is entered for that stage.

## Structure
- Package rst_seq_pkg holds:
  - state enum: STRETCH, GAP, WAIT, RUN, SOFT.
  - stage-index width (3 bits).
  - constant for the maximum number of stages (8).
- Sub-module rst_sync2: 2-flop synchronizer with asynchronous assert and synchronous deassert, clocked by clk_100. It is reused elsewhere for other reset inputs.
- Counters:
  - one shared down-counter, STRETCH_W bits wide, serving both stretch and gap;
  - one separate TMO_W timeout counter.

## Test plan
- Power-up, defaults, stage_rdy=3'b111 → rst_out[0] falls at edge 8210, [1] at 8227, [2] at 8244; seq_done=1 at 8245.
- stage_rdy[1] held 0 for 100 cycles after rst_out[1] falls → rst_out[2] falls exactly GAP_CYC+1 cycles after rdy[1] rises; tmo_err stays 0.
- TMO_W=4, stage_rdy[1]=0 permanently → tmo_err=1 and tmo_stage=1 after 15 WAIT cycles; rst_out[2] still released; seq_done=1.
- Pulse soft_req in RUN → soft_ack single cycle, rst_out=3'b111, rst_out[0] falls 32 cycles later. A soft_req held through re-sequencing produces no second ack before RUN.
- Assert rst_100 mid-GAP of stage 1 → rst_out=3'b111 asynchronously and tmo_err cleared. The full stretch repeats after release.
- soft_req asserted during STRETCH or WAIT → no soft_ack; the sequence completes undisturbed.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the J68 reset sequencer.
package rst_seq_pkg;

   localparam int IDX_W      = 3;
   localparam int MAX_STAGES = 8;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      STRETCH = 3'd0,
      GAP     = 3'd1,
      WAIT    = 3'd2,
      RUN     = 3'd3,
      SOFT    = 3'd4
   } state_e;

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clock edge.
module rst_sync2 (
   input  logic clk,
   input  logic rst_in,
   output logic rst_out
);

   logic meta_q, sync_q;
   logic meta_d, sync_d;

   always_comb begin
      meta_d = 1'b0;
      sync_d = meta_q;
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign rst_out = sync_q;

endmodule

// File: rtl/rst_seq_100.sv
// J68 100 MHz reset sequencer: power-on stretch, ordered per-stage release with
// ready/timeout handshakes, and a handshaked soft reset that skips the stretch.
module rst_seq_100
   import rst_seq_pkg::*;
#(
   parameter int N_STAGES  = 3,
   parameter int STRETCH_W = 13,
   parameter int GAP_CYC   = 16,
   parameter int TMO_W     = 16
) (
   input  logic                clk_100,
   input  logic                rst_100,
   input  logic                soft_req,
   output logic                soft_ack,
   input  logic [N_STAGES-1:0] stage_rdy,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_done,
   output logic                tmo_err,
   output logic [2:0]          tmo_stage
);

   // The shared counter also holds the gap reload, so STRETCH_W must cover GAP_CYC.
   localparam logic [STRETCH_W-1:0] CNT_ONE  = STRETCH_W'(1);
   localparam logic [STRETCH_W-1:0] GAP_LOAD = STRETCH_W'(GAP_CYC);
   localparam logic [TMO_W-1:0]     TMO_LAST = ~TMO_W'(1);
   localparam idx_t                 LAST_IDX = idx_t'(N_STAGES - 1);
   localparam logic [N_STAGES-1:0]  BIT0     = N_STAGES'(1);

   logic rst_sync;

   state_e               state_q, state_d;
   idx_t                 idx_q, idx_d;
   logic [STRETCH_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [N_STAGES-1:0]  rst_out_q, rst_out_d;
   logic                 soft_ack_q, soft_ack_d;
   logic                 tmo_err_q, tmo_err_d;
   idx_t                 tmo_stage_q, tmo_stage_d;

   logic [N_STAGES-1:0]  stage_mask;
   logic                 rdy_sel;
   logic                 tmo_hit;

   rst_sync2 u_rst_sync (
      .clk     (clk_100),
      .rst_in  (rst_100),
      .rst_out (rst_sync)
   );

   assign stage_mask = BIT0 << idx_q;
   assign rdy_sel    = |(stage_rdy & stage_mask);
   // The timeout fires on the cycle whose increment would reach the all-ones count.
   assign tmo_hit    = (tmo_q == TMO_LAST);

   always_ff @(posedge clk_100 or posedge rst_100) begin
      if (rst_100) begin
         state_q     <= STRETCH;
         idx_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         rst_out_q   <= '1;
         soft_ack_q  <= 1'b0;
         tmo_err_q   <= 1'b0;
         tmo_stage_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         rst_out_q   <= rst_out_d;
         soft_ack_q  <= soft_ack_d;
         tmo_err_q   <= tmo_err_d;
         tmo_stage_q <= tmo_stage_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      tmo_d       = '0;
      rst_out_d   = rst_out_q;
      soft_ack_d  = 1'b0;
      tmo_err_d   = tmo_err_q;
      tmo_stage_d = tmo_stage_q;

      if (rst_sync) begin
         state_d   = STRETCH;
         idx_d     = '0;
         cnt_d     = '0;
         rst_out_d = '1;
      end else begin
         case (state_q)
            STRETCH: begin
               // Counting down from zero wraps, so hitting one marks 2^STRETCH_W cycles.
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = GAP;
                  idx_d   = '0;
                  cnt_d   = GAP_LOAD;
               end
            end
            GAP: begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  rst_out_d = rst_out_q & ~stage_mask;
                  state_d   = WAIT;
               end
            end
            WAIT: begin
               tmo_d = tmo_q + TMO_W'(1);
               if (rdy_sel || tmo_hit) begin
                  if (!rdy_sel) begin
                     tmo_err_d   = 1'b1;
                     tmo_stage_d = idx_q;
                  end
                  tmo_d = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d = RUN;
                  end else begin
                     idx_d   = idx_q + idx_t'(1);
                     state_d = GAP;
                     cnt_d   = GAP_LOAD;
                  end
               end
            end
            RUN: begin
               if (soft_req) begin
                  soft_ack_d = 1'b1;
                  rst_out_d  = '1;
                  state_d    = SOFT;
                  cnt_d      = GAP_LOAD;
               end
            end
            SOFT: begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = GAP;
                  idx_d   = '0;
                  cnt_d   = GAP_LOAD;
               end
            end
            default: begin
               state_d = STRETCH;
            end
         endcase
      end
   end

   always_comb begin
      seq_done  = (state_q == RUN);
      rst_out   = rst_out_q;
      soft_ack  = soft_ack_q;
      tmo_err   = tmo_err_q;
      tmo_stage = tmo_stage_q;
   end

endmodule

// File: tb/tb_rst_seq_100.sv
// Directed bench for rst_seq_100: default instance for sequencing/soft reset,
// a short-timeout instance for the timeout and sticky-error behaviour.
module tb_rst_seq_100;

   localparam int P_DONE   = 6;
   localparam int P_DONE_B = 7;
   localparam int P_TMO_B  = 8;
   localparam int P_ACK    = 9;
   localparam int P_ACK_B  = 10;
   localparam int BUDGET   = 9000;

   logic       clk_100 = 1'b0;
   logic       rst_100, soft_req, soft_ack, seq_done, tmo_err;
   logic [2:0] stage_rdy, rst_out, tmo_stage;
   logic       rst_b, soft_req_b, soft_ack_b, seq_done_b, tmo_err_b;
   logic [2:0] stage_rdy_b, rst_out_b, tmo_stage_b;

   always #5 clk_100 = ~clk_100;

   rst_seq_100 dut (
      .clk_100   (clk_100),
      .rst_100   (rst_100),
      .soft_req  (soft_req),
      .soft_ack  (soft_ack),
      .stage_rdy (stage_rdy),
      .rst_out   (rst_out),
      .seq_done  (seq_done),
      .tmo_err   (tmo_err),
      .tmo_stage (tmo_stage)
   );

   rst_seq_100 #(
      .N_STAGES  (3),
      .STRETCH_W (8),
      .GAP_CYC   (16),
      .TMO_W     (4)
   ) dut_b (
      .clk_100   (clk_100),
      .rst_100   (rst_b),
      .soft_req  (soft_req_b),
      .soft_ack  (soft_ack_b),
      .stage_rdy (stage_rdy_b),
      .rst_out   (rst_out_b),
      .seq_done  (seq_done_b),
      .tmo_err   (tmo_err_b),
      .tmo_stage (tmo_stage_b)
   );

   typedef struct {
      string      name;
      int         which;
      logic       val;
      int         exp_edge;
      logic [2:0] exp_rst;
      logic [2:0] rdy;
   } vec_t;

   vec_t vecs [8];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ack_cnt = 0;

   // cyc equals the number of rising edges seen so far when read at a falling edge
   always @(posedge clk_100) begin
      cyc <= cyc + 1;
      if (soft_ack) ack_cnt <= ack_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic logic probe(input int which);
      logic [15:0] pv;
      pv = {5'b0, soft_ack_b, soft_ack, tmo_err_b, seq_done_b, seq_done, rst_out_b, rst_out};
      return pv[which[3:0]];
   endfunction

   task automatic wait_val(input string name, input int which, input logic val,
                           input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_100);
         if (probe(which) === val) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no event within %0d cycles", name, budget);
      end
   endtask

   task automatic apply_vecs(input int lo, input int hi, input int origin);
      int at;
      for (int i = lo; i <= hi; i++) begin
         stage_rdy = vecs[i].rdy;
         wait_val(vecs[i].name, vecs[i].which, vecs[i].val, BUDGET, at);
         check({vecs[i].name, "_edge"}, at - origin, vecs[i].exp_edge);
         check({vecs[i].name, "_rst"}, 32'(rst_out), 32'(vecs[i].exp_rst));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int at, base, base_b, s_abs, t_r, ack0;

      // power-up release with stage_rdy tied high, then the same after a soft reset
      vecs[0] = '{"pu_rst0", 0,      1'b0, 8210, 3'b110, 3'b111};
      vecs[1] = '{"pu_rst1", 1,      1'b0, 8227, 3'b100, 3'b111};
      vecs[2] = '{"pu_rst2", 2,      1'b0, 8244, 3'b000, 3'b111};
      vecs[3] = '{"pu_done", P_DONE, 1'b1, 8245, 3'b000, 3'b111};
      vecs[4] = '{"sr_rst0", 0,      1'b0, 32,   3'b110, 3'b111};
      vecs[5] = '{"sr_rst1", 1,      1'b0, 49,   3'b100, 3'b111};
      vecs[6] = '{"sr_rst2", 2,      1'b0, 66,   3'b000, 3'b111};
      vecs[7] = '{"sr_done", P_DONE, 1'b1, 67,   3'b000, 3'b111};

      rst_100     = 1'b0;
      rst_b       = 1'b0;
      soft_req    = 1'b0;
      soft_req_b  = 1'b0;
      stage_rdy   = 3'b111;
      stage_rdy_b = 3'b101;
      #1;
      rst_100 = 1'b1;
      rst_b   = 1'b1;
      repeat (3) @(negedge clk_100);

      check("rst_rst_out",   32'(rst_out),   32'(3'b111));
      check("rst_soft_ack",  32'(soft_ack),  32'(1'b0));
      check("rst_seq_done",  32'(seq_done),  32'(1'b0));
      check("rst_tmo_err",   32'(tmo_err),   32'(1'b0));
      check("rst_tmo_stage", 32'(tmo_stage), 32'(3'b000));

      // Short-timeout instance: stage 1 never becomes ready.
      rst_b  = 1'b0;
      base_b = cyc;
      wait_val("b_rst1", 4, 1'b0, 400, at);
      check("b_rst1_edge", at - base_b, 291);
      check("b_tmo_pre", 32'(tmo_err_b), 32'(1'b0));
      wait_val("b_tmo", P_TMO_B, 1'b1, 40, at);
      check("b_tmo_edge", at - base_b, 306);
      check("b_tmo_stage", 32'(tmo_stage_b), 32'(3'd1));
      wait_val("b_rst2", 5, 1'b0, 40, at);
      check("b_rst2_edge", at - base_b, 322);
      wait_val("b_done", P_DONE_B, 1'b1, 10, at);
      check("b_done_edge", at - base_b, 323);
      check("b_done_rst", 32'(rst_out_b), 32'(3'b000));

      // Soft reset keeps the sticky error; rst mid-GAP of stage 1 clears everything.
      soft_req_b = 1'b1;
      wait_val("b_ack", P_ACK_B, 1'b1, 5, at);
      soft_req_b = 1'b0;
      s_abs = at;
      check("b_soft_rst", 32'(rst_out_b), 32'(3'b111));
      check("b_tmo_sticky", 32'(tmo_err_b), 32'(1'b1));
      wait_val("b_sr_rst0", 3, 1'b0, 60, at);
      check("b_sr_rst0_edge", at - s_abs, 32);
      repeat (6) @(negedge clk_100);
      #2 rst_b = 1'b1;
      #1;
      check("b_async_rst", 32'(rst_out_b), 32'(3'b111));
      check("b_async_tmo", 32'(tmo_err_b), 32'(1'b0));
      check("b_async_stage", 32'(tmo_stage_b), 32'(3'b000));

      // Default instance power-up; soft_req during STRETCH must be ignored.
      @(negedge clk_100);
      rst_100 = 1'b0;
      base = cyc;
      repeat (100) @(negedge clk_100);
      soft_req = 1'b1;
      repeat (10) @(negedge clk_100);
      soft_req = 1'b0;
      apply_vecs(0, 3, base);
      check("pu_no_ack", ack_cnt, 0);
      check("pu_tmo_err", 32'(tmo_err), 32'(1'b0));

      // Single soft-reset pulse.
      ack0 = ack_cnt;
      soft_req = 1'b1;
      t_r = cyc;
      wait_val("sr_ack", P_ACK, 1'b1, 5, at);
      soft_req = 1'b0;
      s_abs = at;
      check("sr_ack_lat", at - t_r, 1);
      check("sr_all_rst", 32'(rst_out), 32'(3'b111));
      check("sr_done_low", 32'(seq_done), 32'(1'b0));
      @(negedge clk_100);
      check("sr_ack_width", 32'(soft_ack), 32'(1'b0));
      apply_vecs(4, 7, s_abs);
      check("sr_one_ack", ack_cnt - ack0, 1);

      // Held soft_req, stage 1 ready late by 100 cycles.
      ack0 = ack_cnt;
      stage_rdy = 3'b101;
      soft_req  = 1'b1;
      wait_val("hd_ack", P_ACK, 1'b1, 5, at);
      s_abs = at;
      wait_val("hd_rst1", 1, 1'b0, 100, at);
      check("hd_rst1_edge", at - s_abs, 49);
      repeat (100) @(negedge clk_100);
      check("hd_wait_rst", 32'(rst_out), 32'(3'b100));
      t_r = cyc;
      stage_rdy = 3'b111;
      wait_val("hd_rst2", 2, 1'b0, 40, at);
      check("hd_rst2_edge", at - t_r, 17);
      wait_val("hd_done", P_DONE, 1'b1, 10, at);
      check("hd_done_edge", at - t_r, 18);
      check("hd_no_2nd_ack", ack_cnt - ack0, 1);
      check("hd_tmo_err", 32'(tmo_err), 32'(1'b0));
      wait_val("hd_ack2", P_ACK, 1'b1, 5, at);
      soft_req = 1'b0;
      check("hd_ack2_edge", at - t_r, 19);
      s_abs = at;

      // Async reset mid-GAP of stage 1, then the full stretch again.
      wait_val("ar_rst0", 0, 1'b0, 60, at);
      check("ar_rst0_edge", at - s_abs, 32);
      repeat (8) @(negedge clk_100);
      #2 rst_100 = 1'b1;
      #1;
      check("ar_rst_out", 32'(rst_out), 32'(3'b111));
      check("ar_seq_done", 32'(seq_done), 32'(1'b0));
      repeat (4) @(negedge clk_100);
      rst_100 = 1'b0;
      base = cyc;
      apply_vecs(0, 3, base);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
